// File: rtl/uart_core.sv
// uart_core: 8N1 UART with an 8-bit register port for a bus master.
// Ports: clk_i/arst_n_i clock and async active-low reset;
//   avms_address_i/read_i/write_i/writedata_i/readdata_o register port;
//   uart_txd_o/uart_rxd_i serial pins; IRQ_event high while a byte is unread.
module uart_core #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic [3:0] avms_address_i,
    input  logic       avms_read_i,
    input  logic       avms_write_i,
    input  logic [7:0] avms_writedata_i,
    output logic [7:0] avms_readdata_o,
    output logic       uart_txd_o,
    input  logic       uart_rxd_i,
    output logic       IRQ_event
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ---------------- bus decode ----------------
    logic tx_ready;
    logic wr_tx;
    logic rd_rx;

    // ---------------- transmitter ----------------
    state_t          tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_idx, tx_idx_n;
    logic [7:0]      tx_shift, tx_shift_n;
    logic            tx_line_n;

    assign tx_ready = (tx_state == IDLE);
    assign wr_tx    = avms_write_i && (avms_address_i == 4'h0) && tx_ready;
    assign rd_rx    = avms_read_i && (avms_address_i == 4'h2);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        unique case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (wr_tx) begin
                    tx_state_n = START;
                    tx_shift_n = avms_writedata_i;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = DATA;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_idx == 3'd7) tx_state_n = STOP;
                    else                tx_idx_n   = tx_idx + 3'd1;
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
        // Line level is registered from the next state so the
        // pin changes on the same edge the state does.
        case (tx_state_n)
            START:   tx_line_n = 1'b0;
            DATA:    tx_line_n = tx_shift_n[0];
            default: tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_state   <= IDLE;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            uart_txd_o <= 1'b1;
        end else begin
            tx_state   <= tx_state_n;
            tx_cnt     <= tx_cnt_n;
            tx_idx     <= tx_idx_n;
            tx_shift   <= tx_shift_n;
            uart_txd_o <= tx_line_n;
        end
    end

    // ---------------- receiver ----------------
    logic            rx_meta, rx_sync;
    state_t          rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_idx, rx_idx_n;
    logic [7:0]      rx_shift, rx_shift_n;
    logic            rx_done, rx_ferr;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (!rx_sync) rx_state_n = START;
            end
            START: begin
                // Mid-start check; a line back high was only a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = IDLE;
                    end else begin
                        rx_idx_n   = '0;
                        rx_state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state_n = STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = IDLE;
                    rx_done    = rx_sync;
                    rx_ferr    = !rx_sync;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= uart_rxd_i;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    // ---------------- registers ----------------
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;

    assign IRQ_event = rx_valid;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_data         <= '0;
            rx_valid        <= 1'b0;
            overrun         <= 1'b0;
            frame_err       <= 1'b0;
            avms_readdata_o <= '0;
        end else begin
            if (avms_read_i) begin
                case (avms_address_i)
                    4'h1: avms_readdata_o <= {4'b0, frame_err, overrun,
                                              rx_valid, tx_ready};
                    4'h2: avms_readdata_o <= rx_data;
                    default: avms_readdata_o <= '0;
                endcase
            end
            if (rd_rx) begin
                rx_valid  <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            // A read on the completion edge consumed the old byte,
            // so the new one is not counted as an overrun.
            if (rx_done) begin
                rx_data  <= rx_shift_n;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_rx) overrun <= 1'b1;
            end
            if (rx_ferr) frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core.
// Decodes the TX line and drives RX frames at a short bit period.
module tb_uart_core;

    localparam int CLK_FREQ  = 3_200_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DIV  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int TMO  = 30 * DIV;
    localparam int POLL = 20 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] addr = '0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       txd;
    logic       rxd = 1'b1;
    logic       irq;

    int total = 0;
    int bad = 0;

    uart_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk_i           (clk),
        .arst_n_i        (rst_n),
        .avms_address_i  (addr),
        .avms_read_i     (rd),
        .avms_write_i    (wr),
        .avms_writedata_i(wdata),
        .avms_readdata_o (rdata),
        .uart_txd_o      (txd),
        .uart_rxd_i      (rxd),
        .IRQ_event       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        addr = a;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        addr = a;
        wdata = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    // Finds the next start bit on txd and samples each bit mid-way.
    task automatic tx_capture(output logic [7:0] b, output bit ok,
                              output int waited);
        ok = 1'b1;
        waited = 0;
        b = '0;
        while (txd !== 1'b0 && waited < TMO) begin
            tick();
            waited++;
        end
        if (txd !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) tick();
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) tick();
            b[i] = txd;
        end
        repeat (DIV) tick();
        if (txd !== 1'b1) ok = 1'b0;
    endtask

    // Drives one frame; reports irq just before the stop bit and the
    // number of stop-bit cycles until irq was seen (-1 if never).
    task automatic rx_send(input logic [7:0] b, input bit stop,
                           output bit pre, output int lat);
        rxd = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) tick();
        end
        pre = irq;
        lat = -1;
        rxd = stop;
        for (int k = 0; k < DIV; k++) begin
            tick();
            if (lat < 0 && irq === 1'b1) lat = k + 1;
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int errs;
        repeat (3) tick();
        total++;
        if (txd !== 1'b1) begin
            bad++;
            $display("FAIL reset_txd: got %b want 1", txd);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        total++;
        if (rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_rdata: got %h want 00", rdata);
        end
        rst_n = 1'b1;
        tick();
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL reset_status: got %h want 01", d);
        end
        errs = 0;
        for (int k = 0; k < 4 * DIV; k++) begin
            if (txd !== 1'b1 || irq !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL idle_lines: got %0d bad cycles want 0", errs);
        end
        bus_read(4'h0, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL read_txdata: got %h want 00", d);
        end
        bus_read(4'hF, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL read_unmapped: got %h want 00", d);
        end
        bus_write(4'h2, 8'hFF);
        bus_write(4'h7, 8'hFF);
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h01 || txd !== 1'b1) begin
            bad++;
            $display("FAIL ignored_writes: got %h txd %b want 01 txd 1",
                     d, txd);
        end
    endtask

    task automatic test_single_tx(input logic [7:0] b);
        logic [9:0] frame;
        logic [7:0] mid, fin, st;
        int errs;
        frame = {1'b1, b, 1'b0};
        errs = 0;
        mid = '1;
        fin = '1;
        bus_write(4'h0, b);
        for (int k = 0; k < 10 * DIV; k++) begin
            if (txd !== frame[k / DIV]) errs++;
            if (k == 5 * DIV)          bus_read(4'h1, mid);
            else if (k == 10 * DIV - 1) bus_read(4'h1, fin);
            else                        tick();
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL tx_wave %h: got %0d wrong cycles want 0", b, errs);
        end
        total++;
        if (mid !== 8'h00) begin
            bad++;
            $display("FAIL tx_busy_mid: got %h want 00", mid);
        end
        total++;
        if (fin !== 8'h00) begin
            bad++;
            $display("FAIL tx_busy_last: got %h want 00", fin);
        end
        bus_read(4'h1, st);
        total++;
        if (st !== 8'h01 || txd !== 1'b1) begin
            bad++;
            $display("FAIL tx_done: got %h txd %b want 01 txd 1", st, txd);
        end
    endtask

    task automatic test_tx_stream();
        logic [7:0] exp [12];
        logic [7:0] got [$];
        int fails, poll_fail, max_gap, lows;
        exp = '{8'h48, 8'h45, 8'h4C, 8'h89, 8'h4F, 8'h5F,
                8'h57, 8'h66, 8'h52, 8'h99, 8'h44, 8'h21};
        fails = 0;
        poll_fail = 0;
        max_gap = 0;
        fork
            begin
                logic [7:0] s;
                bit ready;
                int n;
                for (int i = 0; i < 12; i++) begin
                    ready = 1'b0;
                    n = 0;
                    while (!ready && n < POLL) begin
                        bus_read(4'h1, s);
                        ready = s[0];
                        n++;
                    end
                    if (!ready) poll_fail++;
                    bus_write(4'h0, exp[i]);
                    if (i == 3) begin
                        repeat (3 * DIV) tick();
                        bus_write(4'h0, 8'h55);
                    end
                end
            end
            begin
                logic [7:0] b;
                bit ok;
                int w;
                for (int i = 0; i < 12; i++) begin
                    tx_capture(b, ok, w);
                    got.push_back(b);
                    if (!ok) fails++;
                    if (i > 0 && w > max_gap) max_gap = w;
                end
            end
        join
        total++;
        if (poll_fail !== 0 || fails !== 0) begin
            bad++;
            $display("FAIL stream_framing: got poll=%0d frame=%0d want 0 0",
                     poll_fail, fails);
        end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL stream_byte%0d: got %h want %h",
                         i, got[i], exp[i]);
            end
        end
        total++;
        if (max_gap > HALF + 6) begin
            bad++;
            $display("FAIL stream_gap: got %0d want <= %0d",
                     max_gap, HALF + 6);
        end
        lows = 0;
        for (int k = 0; k < 12 * DIV; k++) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL stream_extra: got %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_rx();
        logic [7:0] b, d;
        bit pre;
        int lat;
        for (int i = 0; i < 14; i++) begin
            b = (i < 10) ? 8'(8'h0A + i) : 8'($urandom_range(0, 255));
            rx_send(b, 1'b1, pre, lat);
            total++;
            if (pre !== 1'b0) begin
                bad++;
                $display("FAIL rx_irq_early %h: got %b want 0", b, pre);
            end
            total++;
            if (lat <= HALF || lat > HALF + DIV) begin
                bad++;
                $display("FAIL rx_irq_lat %h: got %0d want %0d..%0d",
                         b, lat, HALF + 1, HALF + DIV);
            end
            bus_read(4'h2, d);
            total++;
            if (d !== b) begin
                bad++;
                $display("FAIL rx_data: got %h want %h", d, b);
            end
            total++;
            if (irq !== 1'b0) begin
                bad++;
                $display("FAIL rx_irq_clear %h: got %b want 0", b, irq);
            end
            repeat (2 * DIV) tick();
        end
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL rx_status_end: got %h want 01", d);
        end
    endtask

    task automatic test_rx_errors();
        logic [7:0] a, b, d;
        bit pre;
        int lat;
        // Two frames unread: second wins and overrun is flagged.
        a = 8'($urandom_range(0, 255));
        b = ~a;
        rx_send(a, 1'b1, pre, lat);
        repeat (DIV) tick();
        rx_send(b, 1'b1, pre, lat);
        repeat (DIV) tick();
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h07) begin
            bad++;
            $display("FAIL overrun_status: got %h want 07", d);
        end
        bus_read(4'h2, d);
        total++;
        if (d !== b) begin
            bad++;
            $display("FAIL overrun_data: got %h want %h", d, b);
        end
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h01 || irq !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: got %h irq %b want 01 irq 0",
                     d, irq);
        end
        // Bad stop bit after a good unread byte.
        a = 8'($urandom_range(0, 255));
        b = ~a;
        rx_send(a, 1'b1, pre, lat);
        repeat (DIV) tick();
        rx_send(b, 1'b0, pre, lat);
        repeat (3 * DIV) tick();
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h0B || irq !== 1'b1) begin
            bad++;
            $display("FAIL ferr_status: got %h irq %b want 0b irq 1",
                     d, irq);
        end
        bus_read(4'h2, d);
        total++;
        if (d !== a) begin
            bad++;
            $display("FAIL ferr_data: got %h want %h", d, a);
        end
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL ferr_clear: got %h want 01", d);
        end
        // Short low pulse must not start a frame.
        rxd = 1'b0;
        repeat (DIV / 4) tick();
        rxd = 1'b1;
        repeat (3 * DIV) tick();
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h01 || irq !== 1'b0) begin
            bad++;
            $display("FAIL glitch: got %h irq %b want 01 irq 0", d, irq);
        end
        // Read of RXDATA on the very edge the next byte completes.
        // Two sync flops, one cycle to leave IDLE and half a bit
        // put the stop sample at edge 3+HALF+9*DIV of the frame.
        a = 8'($urandom_range(0, 255));
        b = ~a;
        rx_send(a, 1'b1, pre, lat);
        repeat (DIV) tick();
        fork
            rx_send(b, 1'b1, pre, lat);
            begin
                repeat (2 + HALF + 9 * DIV) tick();
                bus_read(4'h2, d);
            end
        join
        total++;
        if (d !== a) begin
            bad++;
            $display("FAIL coincide_old: got %h want %h", d, a);
        end
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h03) begin
            bad++;
            $display("FAIL coincide_status: got %h want 03", d);
        end
        bus_read(4'h2, d);
        total++;
        if (d !== b) begin
            bad++;
            $display("FAIL coincide_new: got %h want %h", d, b);
        end
    endtask

    task automatic test_concurrent();
        logic [7:0] t, r, gt, d;
        bit ok, pre;
        int w, lat;
        for (int n = 0; n < 3; n++) begin
            t = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            fork
                begin
                    bus_write(4'h0, t);
                    tx_capture(gt, ok, w);
                end
                rx_send(r, 1'b1, pre, lat);
            join
            repeat (DIV) tick();
            total++;
            if (gt !== t || !ok) begin
                bad++;
                $display("FAIL conc_tx: got %h ok %b want %h ok 1",
                         gt, ok, t);
            end
            bus_read(4'h2, d);
            total++;
            if (d !== r) begin
                bad++;
                $display("FAIL conc_rx: got %h want %h", d, r);
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        int lows;
        bus_write(4'h0, 8'($urandom_range(0, 255)));
        repeat (HALF) tick();
        total++;
        if (txd !== 1'b0) begin
            bad++;
            $display("FAIL midtx_start: got %b want 0", txd);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (txd !== 1'b1 || rdata !== 8'h00) begin
            bad++;
            $display("FAIL midtx_async: got txd %b rdata %h want 1 00",
                     txd, rdata);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus_read(4'h1, d);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL midtx_status: got %h want 01", d);
        end
        lows = 0;
        for (int k = 0; k < 12 * DIV; k++) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL midtx_abort: got %0d low cycles want 0", lows);
        end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_tx(8'h48);
        test_single_tx(8'($urandom_range(0, 255)));
        test_tx_stream();
        test_rx();
        test_rx_errors();
        test_concurrent();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
